// File: rtl/toi2s_pkg.sv
// toi2s_pkg: shared types, limits and helpers for the toi2s serial audio chain
package toi2s_pkg;

  typedef enum logic {
    I2S_STD = 1'b0,
    I2S_LJ  = 1'b1
  } i2s_mode_t;

  localparam int BCK_DIV_MIN = 2;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/toi2s_bck_gen.sv
// toi2s_bck_gen: BCK divider plus frame bit counter; o_bit_idx is the bit that starts at o_bck_fall
module toi2s_bck_gen
  import toi2s_pkg::*;
#(
  parameter int BCK_DIV    = 4,
  parameter int FRAME_BITS = 64,
  localparam int DIV_W     = clog2(BCK_DIV),
  localparam int BIT_W     = clog2(FRAME_BITS)
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             i_ena,
  output logic             o_bck,
  output logic             o_bck_fall,
  output logic [BIT_W-1:0] o_bit_idx,
  output logic             o_frame_boundary
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [BIT_W-1:0] r_bit;
  logic             r_run;
  logic             r_bck;

  // Falling edge on divider wrap; the very first enabled clk is forced to be a frame boundary
  always_comb begin
    o_bck_fall       = i_ena & (~r_run | (r_div == DIV_W'(BCK_DIV - 1)));
    o_frame_boundary = o_bck_fall & (~r_run | (r_bit == BIT_W'(FRAME_BITS - 1)));
    o_bit_idx        = o_frame_boundary ? '0 : r_bit + BIT_W'(1);
    w_div_nxt        = o_bck_fall ? '0 : r_div + DIV_W'(1);
  end

  // Divider, bit counter and registered BCK; ena low clears everything
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      r_div <= '0;
      r_bit <= '0;
      r_run <= 1'b0;
      r_bck <= 1'b0;
    end else begin
      r_div <= i_ena ? w_div_nxt : '0;
      r_bit <= !i_ena ? '0 : o_bck_fall ? o_bit_idx : r_bit;
      r_run <= i_ena;
      r_bck <= i_ena & (w_div_nxt >= DIV_W'(BCK_DIV / 2));
    end

  assign o_bck = r_bck;

endmodule

// File: rtl/toi2s_i2s_tdm_tx.sv
// toi2s_i2s_tdm_tx: double-buffered I2S / left-justified / TDM serial audio transmitter
module toi2s_i2s_tdm_tx
  import toi2s_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int SLOT_W   = 32,
  parameter int N_CH     = 2,
  parameter int BCK_DIV  = 4
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     ena,
  input  logic                     mode,
  input  logic                     mute,
  input  logic [SAMPLE_W*N_CH-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     bck,
  output logic                     ws,
  output logic                     sd,
  output logic                     frame_start,
  output logic                     underrun
);

  localparam int FRAME_W    = SAMPLE_W * N_CH;
  localparam int FRAME_BITS = SLOT_W * N_CH;
  localparam int BIT_W      = clog2(FRAME_BITS);
  localparam int DIV        = (BCK_DIV < BCK_DIV_MIN) ? BCK_DIV_MIN : BCK_DIV;

  logic [FRAME_W-1:0]    r_hold;
  logic                  r_hold_full;
  logic [FRAME_BITS-1:0] r_shift;
  logic [FRAME_BITS-1:0] w_frame;
  logic [FRAME_BITS-1:0] w_load;
  i2s_mode_t             r_mode;
  i2s_mode_t             w_mode;
  logic                  r_mute;
  logic                  w_mute;
  logic                  r_dly;
  logic                  r_ws;
  logic                  r_sd;
  logic                  r_fs;
  logic                  r_ur;
  logic                  w_fall;
  logic                  w_bound;
  logic                  w_ld_bit;
  logic                  w_accept;
  logic                  w_ws;
  logic [BIT_W-1:0]      w_bit;

  toi2s_bck_gen #(
    .BCK_DIV   (DIV),
    .FRAME_BITS(FRAME_BITS)
  ) u_bck_gen (
    .clk             (clk),
    .resetb          (resetb),
    .i_ena           (ena),
    .o_bck           (bck),
    .o_bck_fall      (w_fall),
    .o_bit_idx       (w_bit),
    .o_frame_boundary(w_bound)
  );

  // Spread the held channels into slot layout, MSB of the frame first, padding bits zero
  always_comb begin
    w_frame = '0;
    for (int k = 0; k < N_CH; k++)
      w_frame[FRAME_BITS-1-k*SLOT_W -: SAMPLE_W] = r_hold[k*SAMPLE_W +: SAMPLE_W];
  end

  // Next left-justified bit, shadowed controls (new values take effect at the boundary itself) and ws decode
  always_comb begin
    w_accept = s_valid & s_ready;
    w_load   = r_hold_full ? w_frame : '0;
    w_ld_bit = w_bound ? w_load[FRAME_BITS-1] : r_shift[FRAME_BITS-1];
    w_mode   = w_bound ? i2s_mode_t'(mode) : r_mode;
    w_mute   = w_bound ? mute : r_mute;
    w_ws     = (N_CH == 2) ? (w_bit >= BIT_W'(SLOT_W)) : (w_bit == '0);
  end

  // Holding register: filled by the handshake, emptied when the boundary moves it to the shifter
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (!ena) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_accept) r_hold <= s_data;
      r_hold_full <= w_accept | (r_hold_full & ~w_bound);
    end

  // Serialiser: shifter, I2S one-bit delay, shadows and registered outputs, all stepping on BCK fall
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      r_shift <= '0;
      r_dly   <= 1'b0;
      r_sd    <= 1'b0;
      r_ws    <= 1'b0;
      r_mode  <= I2S_STD;
      r_mute  <= 1'b0;
      r_fs    <= 1'b0;
      r_ur    <= 1'b0;
    end else if (!ena) begin
      r_shift <= '0;
      r_dly   <= 1'b0;
      r_sd    <= 1'b0;
      r_ws    <= 1'b0;
      r_mode  <= I2S_STD;
      r_mute  <= 1'b0;
      r_fs    <= 1'b0;
      r_ur    <= 1'b0;
    end else begin
      if (w_fall) begin
        r_shift <= (w_bound ? w_load : r_shift) << 1;
        r_dly   <= w_ld_bit;
        r_sd    <= ~w_mute & ((w_mode == I2S_LJ) ? w_ld_bit : r_dly);
        r_ws    <= w_ws;
      end
      r_mode <= w_mode;
      r_mute <= w_mute;
      r_fs   <= w_bound;
      r_ur   <= w_bound & ~r_hold_full;
    end

  assign s_ready     = ena & ~r_hold_full;
  assign ws          = r_ws;
  assign sd          = r_sd;
  assign frame_start = r_fs;
  assign underrun    = r_ur;

endmodule
